// File: rtl/fifo_rd_stream_if.sv
// Interface bundle for fifo_rd_stream: the FIFO read port and the downstream
// valid/ready stream. The master modport is the consumer block's view.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_W = 8
);
  // FIFO read side
  logic              o_rden;
  logic [DATA_W-1:0] i_rddata;
  logic              i_empty;
  // Downstream stream side
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  modport master (
    output o_rden,
    input  i_rddata,
    input  i_empty,
    output o_valid,
    output o_data,
    input  i_ready
  );

  modport slave (
    input  o_rden,
    output i_rddata,
    output i_empty,
    input  o_valid,
    input  o_data,
    output i_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for a synchronous FIFO with 1-cycle read latency.
// Words are pulled into a 2-entry skid buffer and presented as a valid/ready
// stream; a wrapping counter tracks words accepted downstream.
module fifo_rd_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  fifo_rd_stream_if.master    bus,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_count
);

  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop;
  logic              rden;
  logic [2:0]        occ;

  // Read-enable decision: never let buffered + in-flight words exceed two
  always_comb begin
    pop  = (buf_cnt_q != 2'd0) & bus.i_ready;
    occ  = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    // occ - pop < 2, rearranged to avoid underflow
    rden = ~rst & i_en & ~bus.i_empty & (occ < (3'd2 + {2'b00, pop}));
  end

  // Skid-buffer next state: capture returning read data, advance head on pop
  always_comb begin
    buf_cnt_d  = buf_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rden;
    count_d    = count_q + {{(CNT_W-1){1'b0}}, pop};
    case ({inflight_q, pop})
      2'b01: begin
        head_d    = tail_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b10: begin
        if (buf_cnt_q == 2'd0) head_d = bus.i_rddata;
        else                   tail_d = bus.i_rddata;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains
        if (buf_cnt_q == 2'd1) begin
          head_d = bus.i_rddata;
        end else begin
          head_d = tail_q;
          tail_d = bus.i_rddata;
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt_q  <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Outputs are direct functions of registered state (plus the read enable)
  always_comb begin
    bus.o_rden  = rden;
    bus.o_valid = (buf_cnt_q != 2'd0);
    bus.o_data  = head_q;
    o_busy      = (buf_cnt_q != 2'd0) | inflight_q;
    o_count     = count_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized self-checking bench for fifo_rd_stream. A queue-based FIFO model
// feeds the DUT; a scoreboard of pushed words checks order, loss and count.
module tb_fifo_rd_stream;
  localparam int unsigned DW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en;
  logic        busy, busy4;
  logic [15:0] count;
  logic [3:0]  count4;

  fifo_rd_stream_if #(.DATA_W(DW)) bus ();
  fifo_rd_stream_if #(.DATA_W(DW)) bus4 ();

  fifo_rd_stream #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_en    (en),
    .bus     (bus),
    .o_busy  (busy),
    .o_count (count)
  );

  // Narrow-counter copy sees identical inputs; only its counter is examined
  fifo_rd_stream #(.DATA_W(DW), .CNT_W(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .i_en    (en),
    .bus     (bus4),
    .o_busy  (busy4),
    .o_count (count4)
  );

  assign bus4.i_rddata = bus.i_rddata;
  assign bus4.i_empty  = bus.i_empty;
  assign bus4.i_ready  = bus.i_ready;

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  int          reads = 0;
  int          pops  = 0;
  int unsigned cnt_model = 0;

  // FIFO model: 1-cycle read latency, registered empty flag; contents survive reset
  always @(posedge clk) begin
    if (bus.o_rden && fifo_q.size() > 0) bus.i_rddata <= fifo_q.pop_front();
    bus.i_empty <= (fifo_q.size() == 0);
  end

  // Scoreboard and invariants sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      int  held;
      bit  pop;
      held = reads - pops;
      pop  = bus.o_valid && bus.i_ready;
      checks++;
      if (count !== cnt_model[15:0])
        $display("FAIL count16 got=%0d want=%0d", count, cnt_model[15:0]);
      if (count !== cnt_model[15:0]) errors++;
      checks++;
      if (count4 !== cnt_model[3:0]) begin
        errors++;
        $display("FAIL count4 got=%0d want=%0d", count4, cnt_model[3:0]);
      end
      checks++;
      if (busy !== (held != 0)) begin
        errors++;
        $display("FAIL busy got=%b want=%b", busy, held != 0);
      end
      if (bus.o_rden) begin
        checks++;
        if (held - (pop ? 1 : 0) >= 2) begin
          errors++;
          $display("FAIL rden_overflow got=rden held=%0d want=no read", held);
        end
        reads++;
      end
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word got=%h want=none", bus.o_data);
        end else begin
          if (bus.o_data !== exp_q[0]) begin
            errors++;
            $display("FAIL order got=%h want=%h", bus.o_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        pops++;
        cnt_model++;
      end
    end
  end

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Words read but not yet delivered are lost when reset hits
  task automatic model_reset();
    int lost;
    lost = reads - pops;
    for (int i = 0; i < lost; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
    reads = pops;
    cnt_model = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && bus.i_empty === 1'b1 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    bus.i_ready = 1'b1;
    push(8'h5A);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.o_rden !== 1'b0) begin
      errors++; $display("FAIL reset_rden got=%b want=0", bus.o_rden);
    end
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b want=0", bus.o_valid);
    end
    checks++;
    if (bus.o_data !== 8'h00) begin
      errors++; $display("FAIL reset_data got=%h want=00", bus.o_data);
    end
    checks++;
    if (busy !== 1'b0 || count !== 16'd0) begin
      errors++; $display("FAIL reset_busy_count got=%b/%0d want=0/0", busy, count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic       rd_h[16];
    logic       v_h[16];
    logic [7:0] d_h[16];
    logic [7:0] w[3];
    int         f;
    bit         ok;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    apply_reset();
    for (int i = 0; i < 3; i++) push(w[i]);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rd_h[k] = bus.o_rden; v_h[k] = bus.o_valid; d_h[k] = bus.o_data;
    end
    f = -1;
    for (int k = 0; k < 16; k++) if (f < 0 && rd_h[k] === 1'b1) f = k;
    checks++;
    if (f < 0 || f > 9) begin
      errors++; $display("FAIL basic_first_rden got=%0d want=0..9", f);
    end else begin
      checks++;
      if ({rd_h[f], rd_h[f+1], rd_h[f+2], rd_h[f+3]} !== 4'b1110) begin
        errors++;
        $display("FAIL basic_rden_run got=%b%b%b%b want=1110",
                 rd_h[f], rd_h[f+1], rd_h[f+2], rd_h[f+3]);
      end
      checks++;
      if (v_h[f+1] !== 1'b0) begin
        errors++; $display("FAIL basic_latency_early got=%b want=0", v_h[f+1]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (v_h[f+2+i] !== 1'b1 || d_h[f+2+i] !== w[i]) begin
          errors++;
          $display("FAIL basic_word%0d got=%b/%h want=1/%h", i, v_h[f+2+i], d_h[f+2+i], w[i]);
        end
      end
      checks++;
      if (v_h[f+5] !== 1'b0) begin
        errors++; $display("FAIL basic_valid_drop got=%b want=0", v_h[f+5]);
      end
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || count !== 16'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_end got=ok%0d/%0d/%b want=ok1/3/0", ok, count, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w0;
    int         nrd;
    int         gaps;
    int         bad;
    int unsigned c0;
    bit         ok;
    c0 = cnt_model;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    w0 = exp_q[0];
    nrd = 0; bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.o_rden === 1'b1) nrd++;
      if (k >= 4 && (bus.o_valid !== 1'b1 || bus.o_data !== w0)) bad++;
    end
    checks++;
    if (nrd != 2) begin
      errors++; $display("FAIL bp_rden_pulses got=%0d want=2", nrd);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_head_hold got=%0d bad cycles want=0", bad);
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    gaps = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b1) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL bp_gaps got=%0d want=0", gaps);
    end
    wait_idle(50, ok);
    checks++;
    if (!ok || count !== 16'(c0 + 8)) begin
      errors++; $display("FAIL bp_count got=ok%0d/%0d want=ok1/%0d", ok, count, c0 + 8);
    end
  endtask

  task automatic test_toggle();
    int p0;
    bit ok;
    p0 = pops;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'($urandom));
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      bus.i_ready = ~bus.i_ready;
      if (fifo_q.size() == 0 && bus.i_empty === 1'b1 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.i_ready = 1'b1;
    checks++;
    if (!ok || pops - p0 != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle got=ok%0d/%0d left=%0d want=ok1/16 left=0", ok, pops - p0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit ok;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_rden === 1'b1 && busy === 1'b1 && bus.o_valid === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rmid_setup got=not reached want=second read in flight");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || busy !== 1'b0 || count !== 16'd0) begin
      errors++;
      $display("FAIL rmid_async got=%b/%b/%0d want=0/0/0", bus.o_valid, busy, count);
    end
    checks++;
    if (bus.o_rden !== 1'b0) begin
      errors++; $display("FAIL rmid_rden got=%b want=0", bus.o_rden);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    bus.i_ready = 1'b1;
    wait_idle(60, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || count !== 16'd3) begin
      errors++;
      $display("FAIL rmid_resume got=ok%0d left=%0d cnt=%0d want=ok1 left=0 cnt=3",
               ok, exp_q.size(), count);
    end
  endtask

  task automatic test_en_drop();
    int p0;
    int nrd;
    bit found;
    bit ok;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.o_rden === 1'b1) begin found = 1'b1; break; end
    end
    p0 = pops;
    @(posedge clk); #1;
    en = 1'b0;
    nrd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.o_rden === 1'b1) nrd++;
    end
    checks++;
    if (!found || nrd != 0) begin
      errors++; $display("FAIL endrop_rden got=found%0d/%0d want=found1/0", found, nrd);
    end
    checks++;
    if (pops - p0 != 1) begin
      errors++; $display("FAIL endrop_inflight got=%0d delivered want=1", pops - p0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    wait_idle(50, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL endrop_drain got=ok%0d left=%0d want=ok1 left=0", ok, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'($urandom));
    wait_idle(80, ok);
    checks++;
    if (!ok || count4 !== 4'd1 || count !== 16'd17) begin
      errors++; $display("FAIL wrap got=ok%0d/%0d/%0d want=ok1/1/17", ok, count4, count);
    end
  endtask

  task automatic test_random();
    int p0;
    int pushed;
    bit ok;
    p0 = pops;
    pushed = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      bus.i_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        push(8'($urandom));
        pushed++;
      end
    end
    @(posedge clk); #1;
    bus.i_ready = 1'b1;
    en = 1'b1;
    wait_idle(600, ok);
    checks++;
    if (!ok || pops - p0 != pushed || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random got=ok%0d/%0d want=ok1/%0d", ok, pops - p0, pushed);
    end
  endtask

  initial begin
    en = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_en_drop();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
